// File: rtl/adafruit_andere_v1_0_s00_axi.sv
//-----------------------------------------------------------------------------
// adafruit_andere_v1_0_s00_axi
//
// AXI4-Lite slave register file for the adafruit_andere peripheral. Four
// 32-bit read/write control registers with byte strobes. The write-address
// and write-data channels are accepted independently (either order or the
// same cycle). At most one write is outstanding: both channels stall while a
// write response is pending. The read path is fully independent of the write
// path.
//
// Parameters:
//   C_S_AXI_DATA_WIDTH : data width, only 32 is supported
//   C_S_AXI_ADDR_WIDTH : byte-address width (>= 4). Register index is
//                        addr[3:2]; any nonzero bit above bit 3 is out of
//                        range and answered with SLVERR.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN      : clock, async active-low reset
//   S_AXI_AW*                      : write-address channel (AWPROT ignored)
//   S_AXI_W*                       : write-data channel with byte strobes
//   S_AXI_B*                       : write-response channel
//   S_AXI_AR*                      : read-address channel (ARPROT ignored)
//   S_AXI_R*                       : read-data channel
//   slv_reg0..slv_reg3             : current register contents for user logic
//-----------------------------------------------------------------------------
module adafruit_andere_v1_0_s00_axi #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     slv_reg3
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // An address is in range when nothing above the 16-byte register window
    // is set.
    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ((addr >> 32'd4) == {AW{1'b0}});
    endfunction

    // Byte-lane merge: lanes with a set strobe take the new data, the rest
    // keep the old register contents.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] result;
        result = old_val;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            aw_held_q, aw_held_d;
    logic [AW-1:0]   awaddr_q,  awaddr_d;
    logic            w_held_q,  w_held_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [SW-1:0]   wstrb_q,   wstrb_d;
    logic            bvalid_q,  bvalid_d;
    logic [1:0]      bresp_q,   bresp_d;
    logic            rvalid_q,  rvalid_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic [1:0]      rresp_q,   rresp_d;
    logic [DW-1:0]   slv_reg_q [4];
    logic [DW-1:0]   slv_reg_d [4];

    // ------------------------------------------------------------------
    // Handshakes and effective write request
    // ------------------------------------------------------------------
    logic            awready_s, wready_s, arready_s;
    logic            aw_hs_s, w_hs_s, ar_hs_s;
    logic            write_fire_s;
    logic [AW-1:0]   wr_addr_s;
    logic [DW-1:0]   wr_data_s;
    logic [SW-1:0]   wr_strb_s;
    logic            unused_ok_s;

    // Ready depends only on registered state so no VALID->READY path exists.
    assign awready_s = ~aw_held_q & ~bvalid_q;
    assign wready_s  = ~w_held_q  & ~bvalid_q;
    assign arready_s = ~rvalid_q;

    assign aw_hs_s = S_AXI_AWVALID & awready_s;
    assign w_hs_s  = S_AXI_WVALID  & wready_s;
    assign ar_hs_s = S_AXI_ARVALID & arready_s;

    // A write fires once both halves are present, whether held from an
    // earlier cycle or arriving on this edge.
    assign write_fire_s = (aw_held_q | aw_hs_s) & (w_held_q | w_hs_s);

    // Take each half from its holding register if it arrived earlier,
    // otherwise straight from the bus.
    assign wr_addr_s = aw_held_q ? awaddr_q : S_AXI_AWADDR;
    assign wr_data_s = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign wr_strb_s = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

    // Protection bits and sub-word address bits carry no meaning here.
    assign unused_ok_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           awaddr_q[1:0], S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write-channel next state: holding registers, response and registers.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        slv_reg_d = slv_reg_q;

        if (aw_hs_s) begin
            awaddr_d = S_AXI_AWADDR;
        end else begin
            awaddr_d = awaddr_q;
        end

        if (w_hs_s) begin
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
        end else begin
            wdata_d = wdata_q;
            wstrb_d = wstrb_q;
        end

        if (write_fire_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (addr_in_range(wr_addr_s)) begin
                slv_reg_d[wr_addr_s[3:2]] = merge_bytes(slv_reg_q[wr_addr_s[3:2]],
                                                        wr_data_s, wr_strb_s);
                bresp_d = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else begin
            // Only one half arrived: park it until the other shows up.
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
            end else begin
                w_held_d = w_held_q;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end
    end

    // Read-channel next state. Data comes from the current register values,
    // so a write firing on the same edge is not visible to this read.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            if (addr_in_range(S_AXI_ARADDR)) begin
                rdata_d = slv_reg_q[S_AXI_ARADDR[3:2]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = {DW{1'b0}};
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
    end

    // State register for both channels and the register file.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= {AW{1'b0}};
            w_held_q  <= 1'b0;
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DW{1'b0}};
            rresp_q   <= RESP_OKAY;
            for (int i = 0; i < 4; i++) begin
                slv_reg_q[i] <= {DW{1'b0}};
            end
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            for (int i = 0; i < 4; i++) begin
                slv_reg_q[i] <= slv_reg_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = awready_s;
    assign S_AXI_WREADY  = wready_s;
    assign S_AXI_ARREADY = arready_s;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign slv_reg0      = slv_reg_q[0];
    assign slv_reg1      = slv_reg_q[1];
    assign slv_reg2      = slv_reg_q[2];
    assign slv_reg3      = slv_reg_q[3];

endmodule

// File: tb/tb_adafruit_andere_v1_0_s00_axi.sv
//-----------------------------------------------------------------------------
// Self-checking bench for adafruit_andere_v1_0_s00_axi (6-bit address so that
// out-of-range accesses exist). Directed scenarios followed by randomized
// write/read traffic, all checked against a word-array model of the register
// file.
//-----------------------------------------------------------------------------
module tb_adafruit_andere_v1_0_s00_axi;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;
    logic          bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0]   reg0, reg1, reg2, reg3;
    logic [31:0]   dut_reg [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the four register words.
    logic [31:0]   model [4];

    always #5 clk = ~clk;

    assign dut_reg[0] = reg0;
    assign dut_reg[1] = reg1;
    assign dut_reg[2] = reg2;
    assign dut_reg[3] = reg3;

    adafruit_andere_v1_0_s00_axi #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .slv_reg0     (reg0),
        .slv_reg1     (reg1),
        .slv_reg2     (reg2),
        .slv_reg3     (reg3)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Model of a completed write; returns the expected BRESP.
    function automatic logic [1:0] model_write(input int addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        if (addr >= 16) return 2'b10;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input int addr);
        if (addr >= 16) return 32'h0;
        return model[addr / 4];
    endfunction

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) chk_eq(tag, dut_reg[i], model[i]);
    endtask

    // Single BREADY edge; response must be gone afterwards.
    task automatic release_b();
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk_eq("bvalid_clear", {31'd0, bvalid}, 32'd1 - 32'd1);
    endtask

    // Write with independent AW and W start delays (in cycles).
    task automatic do_write(input int addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input bit rel);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs, w_hs;
        int c = 0;
        logic [1:0] exp_resp;
        while (!(aw_done && w_done) && c < 64) begin
            awaddr  = addr[AW-1:0];
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            if (w_done && !aw_done) chk_eq("awready_after_w", {31'd0, awready}, 32'd1);
            if (aw_done && !w_done) chk_eq("wready_after_aw", {31'd0, wready}, 32'd1);
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) chk_eq("write_timeout", 32'd0, 32'd1);
        exp_resp = model_write(addr, data, strb);
        chk_eq("bvalid_set", {31'd0, bvalid}, 32'd1);
        chk_eq("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        chk_regs("slv_reg_after_wr");
        if (rel) release_b();
    endtask

    task automatic do_read(input int addr);
        int c = 0;
        araddr  = addr[AW-1:0];
        arvalid = 1'b1;
        while (!arready && c < 32) begin
            @(posedge clk); #1;
            c++;
        end
        if (!arready) chk_eq("read_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk_eq("rvalid_set", {31'd0, rvalid}, 32'd1);
        chk_eq("rdata", rdata, model_read(addr));
        chk_eq("rresp", {30'd0, rresp}, (addr >= 16) ? 32'd2 : 32'd0);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        chk_eq("rvalid_clear", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_awready"}, {31'd0, awready}, 32'd1);
        chk_eq({tag, "_wready"},  {31'd0, wready},  32'd1);
        chk_eq({tag, "_arready"}, {31'd0, arready}, 32'd1);
        chk_eq({tag, "_bvalid"},  {31'd0, bvalid},  32'd0);
        chk_eq({tag, "_bresp"},   {30'd0, bresp},   32'd0);
        chk_eq({tag, "_rvalid"},  {31'd0, rvalid},  32'd0);
        chk_eq({tag, "_rdata"},   rdata,            32'd0);
        chk_eq({tag, "_rresp"},   {30'd0, rresp},   32'd0);
        chk_regs({tag, "_regs"});
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] old_val;
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; wdata = 32'd0; wstrb = 4'd0;
        bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write of all four registers then read back.
        for (int i = 0; i < 4; i++) do_write(4 * i, i + 1, 4'hF, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) do_read(4 * i);
        chk_eq("reg3_const", reg3, 32'h4);

        // W three cycles ahead of AW.
        do_write(8, 32'hDEADBEEF, 4'hF, 3, 0, 1'b1);
        chk_eq("reg2_deadbeef", reg2, 32'hDEADBEEF);

        // Partial strobes.
        do_write(4, 32'h11223344, 4'hF, 0, 0, 1'b1);
        do_write(4, 32'hAABBCCDD, 4'b0101, 0, 0, 1'b1);
        chk_eq("reg1_strobe", reg1, 32'h11BB33DD);

        // Response back-pressure: second pair waits for BREADY.
        do_write(0, 32'hCAFE0001, 4'hF, 0, 0, 1'b0);
        awaddr = 6'hC; wdata = 32'h0BADF00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk_eq("bp_bvalid",  {31'd0, bvalid},  32'd1);
            chk_eq("bp_awready", {31'd0, awready}, 32'd0);
            chk_eq("bp_wready",  {31'd0, wready},  32'd0);
            @(posedge clk); #1;
        end
        chk_regs("bp_no_second_write");
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk_eq("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        chk_regs("bp_still_no_write");
        chk_eq("bp_awready_back", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk_eq("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
        void'(model_write(12, 32'h0BADF00D, 4'hF));
        chk_regs("bp_second_write");
        release_b();

        // Read and write of the same register firing on one edge.
        do_write(4, 32'h2, 4'hF, 0, 0, 1'b1);
        old_val = model[1];
        awaddr = 6'h4; wdata = 32'h55; wstrb = 4'hF; araddr = 6'h4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk_eq("same_edge_rdata", rdata, old_val);
        chk_eq("same_edge_rdata_const", rdata, 32'h2);
        chk_eq("same_edge_bvalid", {31'd0, bvalid}, 32'd1);
        void'(model_write(4, 32'h55, 4'hF));
        rready = 1'b1;
        release_b();
        rready = 1'b0;
        do_read(4);

        // Out-of-range accesses.
        do_write(16, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b1);
        do_read(16);
        do_write(60, 32'h12345678, 4'hF, 1, 0, 1'b1);
        do_read(44);

        // Reset while only the address half of a write is held.
        awaddr = 6'h0; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk_eq("held_awready", {31'd0, awready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        chk_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(0, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b1);
        do_read(0);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            int a;
            a = 4 * $urandom_range(0, 15);
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                @(posedge clk); #1;
                chk_eq("rand_bvalid_hold", {31'd0, bvalid}, 32'd1);
            end
            release_b();
            do_read(4 * $urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
